// File: rtl/vx_mem_req_queue_pkg.sv
// vx_mem_req_queue_pkg
//   Shared types for the Vortex memory request queue.
//   - mem_req_t: one request as it travels Vortex -> slave.
//   - mem_rsp_t: one response as it travels slave -> Vortex.
//   - credit_w(): width of a counter that must hold 0..max_outstanding.
//   Payload widths come from the VX_MEM_* width macros. Fallback defaults are
//   provided here so the block can be built stand-alone.

`ifndef VX_MEM_ADDR_WIDTH
`define VX_MEM_ADDR_WIDTH 26
`endif
`ifndef VX_MEM_DATA_WIDTH
`define VX_MEM_DATA_WIDTH 32
`endif
`ifndef VX_MEM_BYTEEN_WIDTH
`define VX_MEM_BYTEEN_WIDTH 4
`endif
`ifndef VX_MEM_TAG_WIDTH
`define VX_MEM_TAG_WIDTH 8
`endif

package vx_mem_req_queue_pkg;

  localparam int MEM_ADDR_W   = `VX_MEM_ADDR_WIDTH;
  localparam int MEM_DATA_W   = `VX_MEM_DATA_WIDTH;
  localparam int MEM_BYTEEN_W = `VX_MEM_BYTEEN_WIDTH;
  localparam int MEM_TAG_W    = `VX_MEM_TAG_WIDTH;

  typedef struct packed {
    logic                    rw;
    logic [MEM_BYTEEN_W-1:0] byteen;
    logic [MEM_ADDR_W-1:0]   addr;
    logic [MEM_DATA_W-1:0]   data;
    logic [MEM_TAG_W-1:0]    tag;
  } mem_req_t;

  typedef struct packed {
    logic [MEM_DATA_W-1:0] data;
    logic [MEM_TAG_W-1:0]  tag;
  } mem_rsp_t;

  // A credit counter has to reach max_outstanding itself, hence the +1.
  function automatic int credit_w(input int max_outstanding);
    return $clog2(max_outstanding + 1);
  endfunction

endpackage

// File: rtl/vx_mem_queue_fifo.sv
// vx_mem_queue_fifo
//   Synchronous FIFO of DEPTH entries of type T (DEPTH a power of 2, >= 2).
//   Ports:
//     clk, reset          clock, asynchronous active-high reset (empties FIFO)
//     push, push_data     write request; ignored while full (even with a pop)
//     pop, pop_data       read request; pop_data is the current head
//     full, empty         derived only from the registered pointers
//     count               number of stored entries (0..DEPTH)
//   Pointers carry one extra MSB so full and empty are distinguishable; they
//   wrap naturally modulo 2*DEPTH.

module vx_mem_queue_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  T                       push_data,
  input  logic                   pop,
  output T                       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("vx_mem_queue_fifo: DEPTH must be a power of 2 and >= 2");
  end

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Same index with different wrap bits means the writer is a lap ahead.
  assign full     = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                    (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign count    = wr_ptr - rd_ptr;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[IDX_W-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Storage needs no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[IDX_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/vx_mem_req_queue.sv
// vx_mem_req_queue
//   Decoupling queue between the Vortex memory port (up_*) and
//   Vortex_mem_slave (dn_*). Requests and responses are each buffered in a
//   FIFO; a read-credit counter caps in-flight reads so the response FIFO can
//   never overflow, which lets dn_rsp_ready be tied high.
//   Ports:
//     clk, reset                   clock, asynchronous active-high reset
//     up_req_valid/rw/byteen/addr/data/tag, up_req_ready   request from Vortex
//     up_rsp_valid/data/tag, up_rsp_ready                 response to Vortex
//     dn_req_valid/rw/byteen/addr/data/tag, dn_req_ready   request to slave
//     dn_rsp_valid/data/tag, dn_rsp_ready                 response from slave
//     busy                         anything queued or any read credit in use
//     perf_req_cnt                 requests issued downstream
//     perf_stall_cnt               cycles with a queued request not issued
//     perf_peak_occ                peak request FIFO occupancy
//   Configuration:
//     VX_MEM_REQ_QUEUE_PERF_EN     defined: perf counters active (saturating)
//                                  undefined: perf ports tied to 0
//   Payload widths are fixed by vx_mem_req_queue_pkg; the width parameters
//   must agree with it.

module vx_mem_req_queue
  import vx_mem_req_queue_pkg::*;
#(
  parameter int ADDR_W          = MEM_ADDR_W,
  parameter int DATA_W          = MEM_DATA_W,
  parameter int BYTEEN_W        = MEM_BYTEEN_W,
  parameter int TAG_W           = MEM_TAG_W,
  parameter int REQ_DEPTH       = 4,
  parameter int RSP_DEPTH       = 4,
  parameter int MAX_OUTSTANDING = RSP_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       up_req_valid,
  input  logic                       up_req_rw,
  input  logic [BYTEEN_W-1:0]        up_req_byteen,
  input  logic [ADDR_W-1:0]          up_req_addr,
  input  logic [DATA_W-1:0]          up_req_data,
  input  logic [TAG_W-1:0]           up_req_tag,
  output logic                       up_req_ready,
  output logic                       up_rsp_valid,
  output logic [DATA_W-1:0]          up_rsp_data,
  output logic [TAG_W-1:0]           up_rsp_tag,
  input  logic                       up_rsp_ready,
  output logic                       dn_req_valid,
  output logic                       dn_req_rw,
  output logic [BYTEEN_W-1:0]        dn_req_byteen,
  output logic [ADDR_W-1:0]          dn_req_addr,
  output logic [DATA_W-1:0]          dn_req_data,
  output logic [TAG_W-1:0]           dn_req_tag,
  input  logic                       dn_req_ready,
  input  logic                       dn_rsp_valid,
  input  logic [DATA_W-1:0]          dn_rsp_data,
  input  logic [TAG_W-1:0]           dn_rsp_tag,
  output logic                       dn_rsp_ready,
  output logic                       busy,
  output logic [31:0]                perf_req_cnt,
  output logic [31:0]                perf_stall_cnt,
  output logic [$clog2(REQ_DEPTH):0] perf_peak_occ
);

  localparam int CREDIT_W  = credit_w(MAX_OUTSTANDING);
  localparam int REQ_CNT_W = $clog2(REQ_DEPTH) + 1;
  localparam int RSP_CNT_W = $clog2(RSP_DEPTH) + 1;

  if (MAX_OUTSTANDING > RSP_DEPTH || MAX_OUTSTANDING < 1) begin : g_bad_credit
    $error("vx_mem_req_queue: MAX_OUTSTANDING must be in 1..RSP_DEPTH");
  end

  if (ADDR_W != MEM_ADDR_W || DATA_W != MEM_DATA_W ||
      BYTEEN_W != MEM_BYTEEN_W || TAG_W != MEM_TAG_W) begin : g_bad_width
    $error("vx_mem_req_queue: width parameters disagree with vx_mem_req_queue_pkg");
  end

  mem_req_t             up_req;
  mem_req_t             req_head;
  mem_rsp_t             dn_rsp;
  mem_rsp_t             rsp_head;
  logic                 req_full;
  logic                 req_empty;
  logic                 rsp_full;
  logic                 rsp_empty;
  logic [REQ_CNT_W-1:0] req_count;
  logic [RSP_CNT_W-1:0] rsp_count;
  logic                 accepting;
  logic [CREDIT_W-1:0]  credit;
  logic                 req_push;
  logic                 head_gated;
  logic                 dn_fire;
  logic                 rd_issue;
  logic                 rsp_fire;

  assign up_req = '{rw: up_req_rw, byteen: up_req_byteen, addr: up_req_addr,
                    data: up_req_data, tag: up_req_tag};
  assign dn_rsp = '{data: dn_rsp_data, tag: dn_rsp_tag};

  // Holds up_req_ready low through reset and releases it one edge later, so
  // the ready output comes only from flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) accepting <= 1'b0;
    else       accepting <= 1'b1;
  end

  assign up_req_ready = accepting && !req_full;
  assign req_push     = up_req_valid && up_req_ready;

  vx_mem_queue_fifo #(.T(mem_req_t), .DEPTH(REQ_DEPTH)) u_req_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (req_push),
    .push_data (up_req),
    .pop       (dn_fire),
    .pop_data  (req_head),
    .full      (req_full),
    .empty     (req_empty),
    .count     (req_count)
  );

  // A read at the head waits for a credit; nothing overtakes it.
  assign head_gated   = !req_empty && !req_head.rw &&
                        (credit == CREDIT_W'(MAX_OUTSTANDING));
  assign dn_req_valid = !req_empty && !head_gated;
  assign dn_fire      = dn_req_valid && dn_req_ready;
  assign rd_issue     = dn_fire && !req_head.rw;

  assign dn_req_rw     = req_head.rw;
  assign dn_req_byteen = req_head.byteen;
  assign dn_req_addr   = req_head.addr;
  assign dn_req_data   = req_head.data;
  assign dn_req_tag    = req_head.tag;

  // Credits are held until Vortex takes the response, so a credit covers
  // both the in-flight read and its slot in the response FIFO.
  assign dn_rsp_ready = 1'b1;

  vx_mem_queue_fifo #(.T(mem_rsp_t), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (dn_rsp_valid),
    .push_data (dn_rsp),
    .pop       (up_rsp_ready),
    .pop_data  (rsp_head),
    .full      (rsp_full),
    .empty     (rsp_empty),
    .count     (rsp_count)
  );

  assign up_rsp_valid = !rsp_empty;
  assign up_rsp_data  = rsp_head.data;
  assign up_rsp_tag   = rsp_head.tag;
  assign rsp_fire     = up_rsp_valid && up_rsp_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credit <= '0;
    end else begin
      case ({rd_issue, rsp_fire})
        2'b10:   credit <= credit + CREDIT_W'(1);
        2'b01:   if (credit != '0) credit <= credit - CREDIT_W'(1);
        default: credit <= credit;
      endcase
    end
  end

  assign busy = (req_count != '0) || (rsp_count != '0) || (credit != '0);

  a_rsp_no_overflow : assert property (@(posedge clk) disable iff (reset)
    !(dn_rsp_valid && rsp_full))
    else $error("vx_mem_req_queue: dn_rsp_valid while response FIFO is full");

`ifdef VX_MEM_REQ_QUEUE_PERF_EN
  logic [31:0]          req_cnt_q;
  logic [31:0]          stall_cnt_q;
  logic [REQ_CNT_W-1:0] peak_q;

  // Counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_cnt_q   <= '0;
      stall_cnt_q <= '0;
      peak_q      <= '0;
    end else begin
      if (dn_fire && (req_cnt_q != '1))
        req_cnt_q <= req_cnt_q + 32'd1;
      if (!req_empty && !dn_fire && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (req_count > peak_q)
        peak_q <= req_count;
    end
  end

  assign perf_req_cnt   = req_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
  assign perf_peak_occ  = peak_q;
`else
  assign perf_req_cnt   = '0;
  assign perf_stall_cnt = '0;
  assign perf_peak_occ  = '0;
`endif

endmodule

// File: tb/tb_vx_mem_req_queue.sv
`timescale 1ns/1ps

module tb_vx_mem_req_queue;
  import vx_mem_req_queue_pkg::*;

  localparam int REQ_DEPTH = 4;
  localparam int RSP_DEPTH = 4;
  localparam int MAX_OUT   = 4;
  localparam int PEAK_W    = $clog2(REQ_DEPTH) + 1;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    up_req_valid, up_req_rw, up_req_ready;
  logic [MEM_BYTEEN_W-1:0] up_req_byteen;
  logic [MEM_ADDR_W-1:0]   up_req_addr;
  logic [MEM_DATA_W-1:0]   up_req_data;
  logic [MEM_TAG_W-1:0]    up_req_tag;
  logic                    up_rsp_valid, up_rsp_ready;
  logic [MEM_DATA_W-1:0]   up_rsp_data;
  logic [MEM_TAG_W-1:0]    up_rsp_tag;
  logic                    dn_req_valid, dn_req_rw, dn_req_ready;
  logic [MEM_BYTEEN_W-1:0] dn_req_byteen;
  logic [MEM_ADDR_W-1:0]   dn_req_addr;
  logic [MEM_DATA_W-1:0]   dn_req_data;
  logic [MEM_TAG_W-1:0]    dn_req_tag;
  logic                    dn_rsp_valid, dn_rsp_ready;
  logic [MEM_DATA_W-1:0]   dn_rsp_data;
  logic [MEM_TAG_W-1:0]    dn_rsp_tag;
  logic                    busy;
  logic [31:0]             perf_req_cnt, perf_stall_cnt;
  logic [PEAK_W-1:0]       perf_peak_occ;

  vx_mem_req_queue #(
    .ADDR_W(MEM_ADDR_W), .DATA_W(MEM_DATA_W), .BYTEEN_W(MEM_BYTEEN_W),
    .TAG_W(MEM_TAG_W), .REQ_DEPTH(REQ_DEPTH), .RSP_DEPTH(RSP_DEPTH),
    .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .clk(clk), .reset(reset),
    .up_req_valid(up_req_valid), .up_req_rw(up_req_rw), .up_req_byteen(up_req_byteen),
    .up_req_addr(up_req_addr), .up_req_data(up_req_data), .up_req_tag(up_req_tag),
    .up_req_ready(up_req_ready),
    .up_rsp_valid(up_rsp_valid), .up_rsp_data(up_rsp_data), .up_rsp_tag(up_rsp_tag),
    .up_rsp_ready(up_rsp_ready),
    .dn_req_valid(dn_req_valid), .dn_req_rw(dn_req_rw), .dn_req_byteen(dn_req_byteen),
    .dn_req_addr(dn_req_addr), .dn_req_data(dn_req_data), .dn_req_tag(dn_req_tag),
    .dn_req_ready(dn_req_ready),
    .dn_rsp_valid(dn_rsp_valid), .dn_rsp_data(dn_rsp_data), .dn_rsp_tag(dn_rsp_tag),
    .dn_rsp_ready(dn_rsp_ready),
    .busy(busy), .perf_req_cnt(perf_req_cnt), .perf_stall_cnt(perf_stall_cnt),
    .perf_peak_occ(perf_peak_occ)
  );

  always #5 clk = ~clk;

  int nVectors = 0;
  int nMiscompares = 0;

  // Reference model: plain queues plus a credit count.
  mem_req_t             reqQ[$];
  mem_rsp_t             rspQ[$];
  logic [MEM_TAG_W-1:0] slavePend[$];
  int                   credit;
  bit                   outOfReset;
  int                   perfReq, perfStall, perfPeak;

  // Slave behaviour: 0 never responds, 1 responds whenever it can, 2 random.
  int       slaveMode;
  bit       slaveFixed;
  int       dnSeen;
  mem_req_t dnLog[$];
  bit       lastUpFire;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nVectors++;
    if (obs !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit modelIdle();
    return reqQ.size() == 0 && rspQ.size() == 0 && credit == 0 && slavePend.size() == 0;
  endfunction

  // One clock cycle: drive the slave, compare every output with the model,
  // advance the model, then step past the next rising edge.
  task automatic applyStimulus();
    bit       expReady, gated, expDnValid, dnFire, rspFire, upFire;
    mem_req_t obsReq, inReq;
    mem_rsp_t obsRsp;
    if (reset) begin
      reqQ.delete(); rspQ.delete(); slavePend.delete();
      credit = 0; outOfReset = 0; perfReq = 0; perfStall = 0; perfPeak = 0;
    end
    dn_rsp_valid = 1'b0;
    dn_rsp_data  = MEM_DATA_W'($urandom);
    dn_rsp_tag   = MEM_TAG_W'($urandom);
    if (!reset && slavePend.size() > 0 && rspQ.size() < RSP_DEPTH &&
        (slaveMode == 1 || (slaveMode == 2 && $urandom_range(0, 1) == 1))) begin
      dn_rsp_valid = 1'b1;
      dn_rsp_tag   = slavePend[0];
      if (slaveFixed) dn_rsp_data = MEM_DATA_W'(32'hDEADBEEF);
    end
    #1;
    expReady   = outOfReset && !reset && reqQ.size() < REQ_DEPTH;
    gated      = reqQ.size() > 0 && !reqQ[0].rw && credit == MAX_OUT;
    expDnValid = reqQ.size() > 0 && !gated;
    obsReq = '{rw: dn_req_rw, byteen: dn_req_byteen, addr: dn_req_addr,
               data: dn_req_data, tag: dn_req_tag};
    obsRsp = '{data: up_rsp_data, tag: up_rsp_tag};
    checkOutput("up_req_ready", up_req_ready, expReady);
    checkOutput("dn_req_valid", dn_req_valid, expDnValid);
    if (expDnValid) checkOutput("dn_req_payload", obsReq, reqQ[0]);
    checkOutput("up_rsp_valid", up_rsp_valid, rspQ.size() > 0);
    if (rspQ.size() > 0) checkOutput("up_rsp_payload", obsRsp, rspQ[0]);
    checkOutput("busy", busy, reqQ.size() > 0 || rspQ.size() > 0 || credit != 0);
    checkOutput("dn_rsp_ready", dn_rsp_ready, 1'b1);
`ifdef VX_MEM_REQ_QUEUE_PERF_EN
    checkOutput("perf_req_cnt", perf_req_cnt, perfReq);
    checkOutput("perf_stall_cnt", perf_stall_cnt, perfStall);
    checkOutput("perf_peak_occ", perf_peak_occ, perfPeak);
`else
    checkOutput("perf_req_cnt_off", perf_req_cnt, 0);
    checkOutput("perf_stall_cnt_off", perf_stall_cnt, 0);
    checkOutput("perf_peak_occ_off", perf_peak_occ, 0);
`endif
    if (dn_req_valid && dn_req_ready) begin
      dnSeen++;
      dnLog.push_back(obsReq);
    end
    dnFire  = expDnValid && dn_req_ready;
    rspFire = rspQ.size() > 0 && up_rsp_ready;
    upFire  = up_req_valid && expReady;
    inReq = '{rw: up_req_rw, byteen: up_req_byteen, addr: up_req_addr,
              data: up_req_data, tag: up_req_tag};
    if (!reset) begin
      if (reqQ.size() > perfPeak) perfPeak = reqQ.size();
      if (dnFire) perfReq++;
      else if (reqQ.size() > 0) perfStall++;
      if (dnFire) begin
        if (!reqQ[0].rw) begin
          credit++;
          slavePend.push_back(reqQ[0].tag);
        end
        void'(reqQ.pop_front());
      end
      if (rspFire) begin
        void'(rspQ.pop_front());
        if (credit > 0) credit--;
      end
      if (dn_rsp_valid) begin
        rspQ.push_back('{data: dn_rsp_data, tag: dn_rsp_tag});
        void'(slavePend.pop_front());
      end
      if (upFire) reqQ.push_back(inReq);
      outOfReset = 1'b1;
    end
    lastUpFire = upFire;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic pushReq(input bit rw, input logic [MEM_ADDR_W-1:0] addr,
                         input logic [MEM_TAG_W-1:0] tag);
    int waited = 0;
    up_req_valid  = 1'b1;
    up_req_rw     = rw;
    up_req_addr   = addr;
    up_req_tag    = tag;
    up_req_byteen = MEM_BYTEEN_W'($urandom);
    up_req_data   = MEM_DATA_W'($urandom);
    do begin
      applyStimulus();
      waited++;
    end while (!lastUpFire && waited < 50);
    checkOutput("push_accepted", lastUpFire, 1'b1);
    up_req_valid = 1'b0;
  endtask

  task automatic drainAll();
    int waited = 0;
    up_req_valid = 1'b0;
    dn_req_ready = 1'b1;
    up_rsp_ready = 1'b1;
    slaveMode    = 1;
    while (!modelIdle() && waited < 200) begin
      applyStimulus();
      waited++;
    end
    checkOutput("drain_busy", busy, 1'b0);
    up_rsp_ready = 1'b0;
    slaveMode    = 0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    up_req_valid = 1'b0; up_req_rw = 1'b0; up_req_byteen = '0; up_req_addr = '0;
    up_req_data = '0; up_req_tag = '0; up_rsp_ready = 1'b0; dn_req_ready = 1'b0;
    dn_rsp_valid = 1'b0; dn_rsp_data = '0; dn_rsp_tag = '0;
    slaveMode = 0; slaveFixed = 1'b0; dnSeen = 0; credit = 0; outOfReset = 1'b0;
    perfReq = 0; perfStall = 0; perfPeak = 0; lastUpFire = 1'b0;

    // Reset held for 13 cycles, then released.
    idle(13);
    checkOutput("rst_up_req_ready", up_req_ready, 1'b0);
    checkOutput("rst_dn_req_valid", dn_req_valid, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    reset = 1'b0;
    applyStimulus();
    checkOutput("rst_release_ready", up_req_ready, 1'b1);

    // Backpressure: four writes pile up, then drain in order.
    dn_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) pushReq(1'b1, MEM_ADDR_W'('h10 + i), MEM_TAG_W'(i));
    checkOutput("bp_ready_full", up_req_ready, 1'b0);
    idle(3);
    dn_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkOutput("bp_order_valid", dn_req_valid, 1'b1);
      checkOutput("bp_order_addr", dn_req_addr, MEM_ADDR_W'('h10 + i));
      applyStimulus();
    end
    checkOutput("bp_drained", dn_req_valid, 1'b0);
`ifdef VX_MEM_REQ_QUEUE_PERF_EN
    checkOutput("bp_perf_req_cnt", perf_req_cnt, 4);
    checkOutput("bp_perf_peak_occ", perf_peak_occ, 4);
    checkOutput("bp_perf_stall_cnt", perf_stall_cnt, 6);
`else
    checkOutput("bp_perf_req_off", perf_req_cnt, 0);
    checkOutput("bp_perf_peak_off", perf_peak_occ, 0);
    checkOutput("bp_perf_stall_off", perf_stall_cnt, 0);
`endif

    // Single read round trip.
    pushReq(1'b0, MEM_ADDR_W'('h3C00000), MEM_TAG_W'('h5));
    checkOutput("rd_dn_valid", dn_req_valid, 1'b1);
    checkOutput("rd_dn_rw", dn_req_rw, 1'b0);
    checkOutput("rd_dn_addr", dn_req_addr, MEM_ADDR_W'('h3C00000));
    checkOutput("rd_dn_tag", dn_req_tag, MEM_TAG_W'('h5));
    applyStimulus();
    slaveFixed = 1'b1; slaveMode = 1;
    applyStimulus();
    slaveFixed = 1'b0; slaveMode = 0;
    checkOutput("rd_rsp_valid", up_rsp_valid, 1'b1);
    checkOutput("rd_rsp_data", up_rsp_data, MEM_DATA_W'(32'hDEADBEEF));
    checkOutput("rd_rsp_tag", up_rsp_tag, MEM_TAG_W'('h5));
    up_rsp_ready = 1'b1;
    applyStimulus();
    up_rsp_ready = 1'b0;
    checkOutput("rd_busy_clear", busy, 1'b0);

    // Credit limit: six reads, silent slave.
    dnSeen = 0;
    for (int i = 0; i < 6; i++) pushReq(1'b0, MEM_ADDR_W'('h100 + i), MEM_TAG_W'('h20 + i));
    idle(3);
    checkOutput("cl_issued", dnSeen, 4);
    checkOutput("cl_head_held", dn_req_valid, 1'b0);
    checkOutput("cl_head_tag", dn_req_tag, MEM_TAG_W'('h24));
    slaveMode = 1;
    applyStimulus();
    slaveMode = 0;
    up_rsp_ready = 1'b1;
    applyStimulus();
    up_rsp_ready = 1'b0;
    checkOutput("cl_fifth_valid", dn_req_valid, 1'b1);
    checkOutput("cl_fifth_tag", dn_req_tag, MEM_TAG_W'('h24));
    drainAll();

    // Mixed traffic behind a gated read.
    for (int i = 0; i < 4; i++) pushReq(1'b0, MEM_ADDR_W'('h200 + i), MEM_TAG_W'('h30 + i));
    idle(2);
    pushReq(1'b0, MEM_ADDR_W'('h300), MEM_TAG_W'('h40));
    pushReq(1'b1, MEM_ADDR_W'('h301), MEM_TAG_W'('h41));
    pushReq(1'b0, MEM_ADDR_W'('h302), MEM_TAG_W'('h42));
    idle(2);
    checkOutput("mx_gated", dn_req_valid, 1'b0);
    dnLog.delete();
    slaveMode = 1;
    applyStimulus();
    slaveMode = 0;
    up_rsp_ready = 1'b1;
    applyStimulus();
    up_rsp_ready = 1'b0;
    checkOutput("mx_first_issue", dn_req_valid, 1'b1);
    drainAll();
    checkOutput("mx_count", dnLog.size(), 3);
    if (dnLog.size() >= 3) begin
      checkOutput("mx_order0", {dnLog[0].rw, dnLog[0].tag}, {1'b0, MEM_TAG_W'('h40)});
      checkOutput("mx_order1", {dnLog[1].rw, dnLog[1].tag}, {1'b1, MEM_TAG_W'('h41)});
      checkOutput("mx_order2", {dnLog[2].rw, dnLog[2].tag}, {1'b0, MEM_TAG_W'('h42)});
    end

    // Random traffic with a reset in the middle.
    slaveMode = 2;
    for (int c = 0; c < 1500; c++) begin
      up_req_valid  = $urandom_range(0, 2) != 0;
      up_req_rw     = $urandom_range(0, 1) == 1;
      up_req_byteen = MEM_BYTEEN_W'($urandom);
      up_req_addr   = MEM_ADDR_W'($urandom);
      up_req_data   = MEM_DATA_W'($urandom);
      up_req_tag    = MEM_TAG_W'($urandom);
      dn_req_ready  = $urandom_range(0, 3) != 0;
      up_rsp_ready  = $urandom_range(0, 2) != 0;
      if (c == 700) reset = 1'b1;
      if (c == 702) reset = 1'b0;
      applyStimulus();
    end
    drainAll();

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
